// File: rtl/montador_linha_if.sv
// Stream-in / line-out bundle for the line assembler.
// The slave side is the assembler; the master side is its environment (DMA feeder + core).
interface montador_linha_if #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned LINE_W    = 512,
    parameter int unsigned NUM_LINES = 4
);
    localparam int unsigned ADDR_W = $clog2(NUM_LINES);

    logic [WORD_W-1:0] in_dado;
    logic              in_valido;
    logic              in_ultimo;
    logic              in_pronto;
    logic [LINE_W-1:0] linha_cache;
    logic [ADDR_W-1:0] endereco;
    logic              linha_valida;
    logic              linha_aceita;
    logic              janela_fim;
    logic              ocupado;

    modport slave (
        input  in_dado,
        input  in_valido,
        input  in_ultimo,
        output in_pronto,
        output linha_cache,
        output endereco,
        output linha_valida,
        input  linha_aceita,
        output janela_fim,
        output ocupado
    );

    modport master (
        output in_dado,
        output in_valido,
        output in_ultimo,
        input  in_pronto,
        input  linha_cache,
        input  endereco,
        input  linha_valida,
        output linha_aceita,
        input  janela_fim,
        input  ocupado
    );
endinterface

// File: rtl/montador_linha.sv
// Assembles a narrow word stream into cache lines for the signature-matching core.
// One line buffer: collection and delivery never overlap. Lines are numbered within
// an analysis window; the end of each window is flagged with a one-cycle pulse.
module montador_linha #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned LINE_W    = 512,
    parameter int unsigned NUM_LINES = 4
) (
    input logic             clk,
    input logic             reset,
    montador_linha_if.slave bus
);
    localparam int unsigned WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int unsigned CNT_W          = $clog2(WORDS_PER_LINE);
    localparam int unsigned ADDR_W         = $clog2(NUM_LINES);

    localparam logic [CNT_W-1:0]  LastWord = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_LINES - 1);

    typedef enum logic [0:0] {StColeta, StEntrega} estado_t;

    estado_t           estado_q, estado_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              ult_q, ult_d;   // pending line was closed by in_ultimo
    logic              fim_q, fim_d;

    // State register; reset discards any partial or undelivered line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= StColeta;
            cnt_q    <= '0;
            buf_q    <= '0;
            end_q    <= '0;
            ult_q    <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            end_q    <= end_d;
            ult_q    <= ult_d;
            fim_q    <= fim_d;
        end
    end

    // Next state: collect words in COLETA, hold the line in ENTREGA until accepted.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        end_d    = end_q;
        ult_d    = ult_q;
        fim_d    = 1'b0;
        unique case (estado_q)
            StColeta: begin
                // in_pronto is high throughout COLETA, so in_valido alone marks a transfer
                if (bus.in_valido) begin
                    buf_d[WORD_W*cnt_q +: WORD_W] = bus.in_dado;
                    cnt_d                         = cnt_q + CNT_W'(1);
                    if (bus.in_ultimo || cnt_q == LastWord) begin
                        estado_d = StEntrega;
                        ult_d    = bus.in_ultimo;
                    end
                end
            end
            StEntrega: begin
                if (bus.linha_aceita) begin
                    estado_d = StColeta;
                    cnt_d    = '0;
                    buf_d    = '0;
                    ult_d    = 1'b0;
                    fim_d    = ult_q || (end_q == LastAddr);
                    // A window closes on its last line or early on end of sample
                    end_d    = (ult_q || end_q == LastAddr) ? '0 : end_q + ADDR_W'(1);
                end
            end
            default: estado_d = StColeta;
        endcase
    end

    // in_pronto is gated by reset so it reads 0 while reset is held.
    assign bus.in_pronto    = reset && (estado_q == StColeta);
    assign bus.linha_valida = (estado_q == StEntrega);
    assign bus.linha_cache  = buf_q;
    assign bus.endereco     = end_q;
    assign bus.janela_fim   = fim_q;
    assign bus.ocupado      = (cnt_q != '0) || (estado_q == StEntrega);
endmodule

// File: tb/tb_montador_linha.sv
// Bench for montador_linha: directed table of lines, hand-written reset sequence,
// then random lines checked against a window/line model built from the stream rules.
module tb_montador_linha;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LINE_W    = 512;
    localparam int unsigned NUM_LINES = 4;
    localparam int unsigned WPL       = LINE_W / WORD_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    montador_linha_if #(.WORD_W(WORD_W), .LINE_W(LINE_W), .NUM_LINES(NUM_LINES)) bus ();

    montador_linha #(.WORD_W(WORD_W), .LINE_W(LINE_W), .NUM_LINES(NUM_LINES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         tipo;     // 0: k, 1: A5A5A5A5, 2: 0x11111111*(k+1), 3: random
        int         n;        // words in line
        bit         ult;      // close with in_ultimo on the last word
        int         atraso;   // cycles before linha_aceita
        int         gap;      // idle % before each word, >=100 means exactly one idle
        logic [1:0] exp_end;
        bit         exp_fim;
    } vetor_t;

    vetor_t            tab [11];
    logic [WORD_W-1:0] ws [WPL];
    int                model_end;

    task automatic chk_bit(input string nome, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nome, act, exp);
        end
    endtask

    task automatic chk_vec(input string nome, input logic [LINE_W-1:0] act,
                           input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] palavra(input int tipo, input int k);
        case (tipo)
            0:       return WORD_W'(k);
            1:       return 32'hA5A5A5A5;
            2:       return 32'h11111111 * WORD_W'(k + 1);
            default: return $urandom;
        endcase
    endfunction

    task automatic ocioso();
        bus.in_valido    = 1'b0;
        bus.in_ultimo    = 1'($urandom_range(1));
        bus.in_dado      = $urandom;
        bus.linha_aceita = 1'($urandom_range(1));   // must be ignored while collecting
        @(negedge clk);
    endtask

    // Streams one line, checks its presentation, holds it, accepts it, checks the window pulse.
    task automatic envia_linha(input logic [WORD_W-1:0] w [WPL], input int n, input bit ult,
                               input int atraso, input int gap, input logic [1:0] exp_end,
                               input bit exp_fim, input string nome);
        logic [LINE_W-1:0] esperado;
        esperado = '0;
        for (int k = 0; k < n; k++) esperado[k*WORD_W +: WORD_W] = w[k];
        for (int k = 0; k < n; k++) begin
            if (gap >= 100) ocioso();
            else while (int'($urandom_range(99)) < gap) ocioso();
            chk_bit({nome, "_pronto"}, bus.in_pronto, 1'b1);
            if (k > 0) chk_bit({nome, "_ocupado_parcial"}, bus.ocupado, 1'b1);
            bus.in_valido    = 1'b1;
            bus.in_dado      = w[k];
            bus.in_ultimo    = ult && (k == n - 1);
            bus.linha_aceita = 1'($urandom_range(1));
            @(negedge clk);
        end
        bus.in_valido    = 1'b0;
        bus.in_ultimo    = 1'b0;
        bus.linha_aceita = 1'b0;
        chk_bit({nome, "_valida"}, bus.linha_valida, 1'b1);
        chk_vec({nome, "_linha"}, bus.linha_cache, esperado);
        chk_vec({nome, "_endereco"}, LINE_W'(bus.endereco), LINE_W'(exp_end));
        chk_bit({nome, "_pronto_entrega"}, bus.in_pronto, 1'b0);
        chk_bit({nome, "_ocupado"}, bus.ocupado, 1'b1);
        chk_bit({nome, "_fim_cedo"}, bus.janela_fim, 1'b0);
        for (int d = 0; d < atraso; d++) begin
            // words offered while a line is pending must not be taken
            bus.in_valido = 1'b1;
            bus.in_dado   = $urandom;
            bus.in_ultimo = 1'($urandom_range(1));
            @(negedge clk);
            chk_bit({nome, "_pronto_espera"}, bus.in_pronto, 1'b0);
            chk_bit({nome, "_valida_espera"}, bus.linha_valida, 1'b1);
            chk_vec({nome, "_linha_estavel"}, bus.linha_cache, esperado);
            chk_vec({nome, "_end_estavel"}, LINE_W'(bus.endereco), LINE_W'(exp_end));
        end
        bus.in_valido    = 1'b0;
        bus.in_ultimo    = 1'b0;
        bus.linha_aceita = 1'b1;
        @(negedge clk);
        bus.linha_aceita = 1'b0;
        chk_bit({nome, "_valida_baixa"}, bus.linha_valida, 1'b0);
        chk_bit({nome, "_fim"}, bus.janela_fim, exp_fim);
        chk_bit({nome, "_pronto_volta"}, bus.in_pronto, 1'b1);
        chk_bit({nome, "_ocupado_livre"}, bus.ocupado, 1'b0);
        @(negedge clk);
        chk_bit({nome, "_fim_pulso"}, bus.janela_fim, 1'b0);
    endtask

    initial begin
        tab[0]  = '{tipo: 0, n: 16, ult: 1'b0, atraso: 0, gap: 0,   exp_end: 2'd0, exp_fim: 1'b0};
        tab[1]  = '{tipo: 0, n: 16, ult: 1'b0, atraso: 5, gap: 0,   exp_end: 2'd1, exp_fim: 1'b0};
        tab[2]  = '{tipo: 1, n: 16, ult: 1'b0, atraso: 0, gap: 0,   exp_end: 2'd2, exp_fim: 1'b0};
        tab[3]  = '{tipo: 1, n: 16, ult: 1'b0, atraso: 1, gap: 0,   exp_end: 2'd3, exp_fim: 1'b1};
        tab[4]  = '{tipo: 1, n: 16, ult: 1'b0, atraso: 0, gap: 0,   exp_end: 2'd0, exp_fim: 1'b0};
        tab[5]  = '{tipo: 1, n: 16, ult: 1'b0, atraso: 2, gap: 0,   exp_end: 2'd1, exp_fim: 1'b0};
        tab[6]  = '{tipo: 1, n: 16, ult: 1'b0, atraso: 0, gap: 0,   exp_end: 2'd2, exp_fim: 1'b0};
        tab[7]  = '{tipo: 1, n: 16, ult: 1'b0, atraso: 0, gap: 0,   exp_end: 2'd3, exp_fim: 1'b1};
        tab[8]  = '{tipo: 1, n: 16, ult: 1'b0, atraso: 0, gap: 0,   exp_end: 2'd0, exp_fim: 1'b0};
        tab[9]  = '{tipo: 2, n: 3,  ult: 1'b1, atraso: 1, gap: 0,   exp_end: 2'd1, exp_fim: 1'b1};
        tab[10] = '{tipo: 0, n: 16, ult: 1'b0, atraso: 0, gap: 100, exp_end: 2'd0, exp_fim: 1'b0};

        reset            = 1'b0;
        bus.in_dado      = '0;
        bus.in_valido    = 1'b0;
        bus.in_ultimo    = 1'b0;
        bus.linha_aceita = 1'b0;
        #1;
        chk_bit("reset_pronto", bus.in_pronto, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_bit("rel_pronto", bus.in_pronto, 1'b1);
        chk_bit("rel_valida", bus.linha_valida, 1'b0);
        chk_vec("rel_linha", bus.linha_cache, '0);
        chk_vec("rel_endereco", LINE_W'(bus.endereco), '0);
        chk_bit("rel_fim", bus.janela_fim, 1'b0);
        chk_bit("rel_ocupado", bus.ocupado, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < int'(WPL); k++) ws[k] = palavra(tab[i].tipo, k);
            envia_linha(ws, tab[i].n, tab[i].ult, tab[i].atraso, tab[i].gap,
                        tab[i].exp_end, tab[i].exp_fim, $sformatf("vet%0d", i));
        end

        // Mid-line asynchronous reset while endereco is 1: everything must clear at once.
        for (int k = 0; k < 7; k++) begin
            bus.in_valido = 1'b1;
            bus.in_dado   = 32'hBAD00000 | WORD_W'(k);
            @(negedge clk);
        end
        bus.in_valido = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk_bit("rst_pronto", bus.in_pronto, 1'b0);
        chk_bit("rst_valida", bus.linha_valida, 1'b0);
        chk_vec("rst_linha", bus.linha_cache, '0);
        chk_vec("rst_endereco", LINE_W'(bus.endereco), '0);
        chk_bit("rst_fim", bus.janela_fim, 1'b0);
        chk_bit("rst_ocupado", bus.ocupado, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_bit("rst_pronto_rel", bus.in_pronto, 1'b1);
        @(negedge clk);
        for (int k = 0; k < int'(WPL); k++) ws[k] = 32'hC0DE0000 + WORD_W'(k);
        envia_linha(ws, 16, 1'b0, 0, 0, 2'd0, 1'b0, "pos_reset");

        // Random lines against the window model: next index is 0 after a window close.
        model_end = 1;
        for (int i = 0; i < 40; i++) begin
            int n;
            bit ult;
            bit fim;
            n   = ($urandom_range(3) == 0) ? int'($urandom_range(15, 1)) : 16;
            ult = (n < 16) ? 1'b1 : 1'($urandom_range(1));
            fim = ult || (model_end == NUM_LINES - 1);
            for (int k = 0; k < int'(WPL); k++) ws[k] = $urandom;
            envia_linha(ws, n, ult, int'($urandom_range(4)), 30, 2'(model_end), fim,
                        $sformatf("rnd%0d", i));
            model_end = fim ? 0 : model_end + 1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/montador_linha.md
Name: montador_linha

Overview:
- Upstream feeder for the signature-matching core.
- Accepts a narrow word stream from the memory/DMA side and assembles it into 512-bit cache lines.
- Presents each completed line with its 2-bit line address (linha_cache, endereco), matching the core's inputs.
- Groups lines into analysis windows of NUM_LINES lines and flags the end of each window, so the core's per-window results can be sampled downstream.

Parameters:
WORD_W, 32, input word width in bits
LINE_W, 512, cache-line width; must be a multiple of WORD_W (WORDS_PER_LINE = LINE_W/WORD_W = 16)
NUM_LINES, 4, lines per window; endereco width = clog2(NUM_LINES) = 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_dado  input  WORD_W  incoming data word
in_valido  input  1  in_dado valid
in_ultimo  input  1  qualifies in_dado as last word of the sample; closes line and window
in_pronto  output  1  block can accept a word this cycle
linha_cache  output  LINE_W  assembled line to core
endereco  output  2  index of presented line within window
linha_valida  output  1  linha_cache/endereco valid
linha_aceita  input  1  core consumes presented line
janela_fim  output  1  one-cycle pulse: last line of window consumed
ocupado  output  1  partial line held or line pending delivery

Behaviour:
- Reset (reset=0, async, any state): FSM to COLETA, word counter 0, line buffer 0, linha_cache 0, endereco 0, linha_valida 0, janela_fim 0, ocupado 0.
  - in_pronto is 0 while reset is asserted and 1 in the first cycle after release.
  - A partially collected line or an undelivered line is discarded.
- Word transfer occurs on a rising edge with in_valido & in_pronto.
  - Word k of a line (k = 0..15) lands in bits [WORD_W*k+WORD_W-1 : WORD_W*k], so the first word is the LSBs.
- FSM states:
  - COLETA: in_pronto=1, linha_valida=0.
    - Each transfer stores the word and increments the word counter.
    - Transfer of word 15, or any transfer with in_ultimo=1: go to ENTREGA. The line is driven on linha_cache from the next cycle, with linha_valida=1. Latency from last-word edge to linha_valida high is 1 cycle.
    - in_ultimo with fewer than 16 words: unreceived word slots are 0.
  - ENTREGA: in_pronto=0, linha_valida=1.
    - linha_cache and endereco are held stable until linha_aceita=1 at a rising edge.
    - On accept: linha_valida drops next cycle, buffer and word counter clear, return to COLETA.
    - On accept: endereco increments, wrapping 3 -> 0. If the delivered line was closed by in_ultimo, endereco returns to 0 regardless of value.
    - On accept: janela_fim pulses high for exactly 1 cycle (the cycle after the accepting edge) when endereco was NUM_LINES-1 or the line was closed by in_ultimo.
- linha_aceita is ignored in COLETA.
- in_dado, in_valido and in_ultimo are ignored in ENTREGA (no transfer, since in_pronto=0).
- Single line buffer; no overlap of collection and delivery, so a fully streamed line costs 16 transfer cycles + 1 + accept wait.
- ocupado = (word counter != 0) | linha_valida.
- in_ultimo with in_valido=0 has no effect.
- Window closing early (sample shorter than 4 lines): later endereco values are simply never presented. A new window starts at endereco 0.

Test Plan:
- Stream words 0x00000000..0x0000000F back-to-back, linha_aceita=1:
  - linha_valida high 1 cycle after the 16th transfer.
  - Word k at bits [32k+31:32k]; endereco=0; janela_fim stays 0.
- Same stream with linha_aceita held 0 for 5 cycles:
  - linha_cache/endereco stable, in_pronto=0, words offered meanwhile are not taken.
  - After accept, in_pronto=1 and endereco=1.
- 4 full lines of 0xA5A5A5A5:
  - endereco presented 0,1,2,3.
  - janela_fim pulses once, after the 4th accept; 5th line presents endereco=0.
- 3 words 0x11111111, 0x22222222, 0x33333333 with in_ultimo on the 3rd while endereco=1:
  - linha_cache[95:0] = 0x333333332222222211111111, remaining bits 0.
  - janela_fim pulses on accept; next endereco=0.
- in_valido toggled every other cycle for 16 words:
  - Exactly 16 transfers, correct word placement, no duplicates.
- Assert reset for 1 cycle after 7 words, mid-line:
  - All outputs 0 immediately (asynchronous).
  - Next 16 words form a fresh line at endereco=0 with no stale data.
